ex_mem_buffer: RTL
==================

Name: ex_mem_buffer

Overview:
- Decoupling buffer between the execute stage (alu and its fpu) and the memory stage.
- Captures each completed execute-stage result with its control bits into a small in-order FIFO and presents the oldest entry to the memory stage under a valid/ready handshake.
- Stalls execute when the FIFO is full or the alu has not finished.
- Produces a registered branch-redirect pulse toward the fetch stage.

Parameters:
- DATA_W, 32, width of alu result, pc and store data.
- REG_ADDR_W, 5, destination register index width.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- valid_ex  in  1  execute stage holds a live instruction.
- alu_ready  in  1  alu/fpu result valid this cycle.
- alu_result_ex  in  DATA_W  alu result.
- branch_alu  in  1  branch/jump taken.
- pc_ex  in  DATA_W  instruction pc.
- imm_ex  in  DATA_W  sign-extended branch offset.
- rd_ex  in  REG_ADDR_W  destination register.
- ctrl_ex  in  4  {mem_to_reg, mem_write, mem_read, reg_write}.
- store_data_ex  in  DATA_W  store operand.
- flush  in  1  discard all buffered and incoming work.
- data_ready_mem  in  1  memory stage accepts head entry.
- valid_mem  out  1  head entry valid.
- alu_result_mem  out  DATA_W  head alu result.
- rd_mem  out  REG_ADDR_W  head destination register.
- ctrl_mem  out  4  head control bits.
- store_data_mem  out  DATA_W  head store operand.
- stall_ex  out  1  execute must hold its inputs.
- branch_taken  out  1  one-cycle redirect pulse.
- branch_target  out  DATA_W  redirect address.
- count  out  clog2(DEPTH+1)  occupied entries.
- stall_cycles  out  CNT_W  saturating stall counter.

Behaviour:
- Reset:
  - All registers clear asynchronously on rstn low; release is synchronous to clk.
  - After reset: valid_mem=0, count=0, branch_taken=0, branch_target=0, stall_cycles=0, payload outputs=0.
- Interface definitions:
  - enq = valid_ex & alu_ready & ~full & ~flush, where full = (count==DEPTH).
  - deq = valid_mem & data_ready_mem & ~flush.
  - stall_ex = valid_ex & (~alu_ready | full). Purely combinational; no dependence on data_ready_mem in the same cycle, so there is no full-bypass path.
- FIFO:
  - Entries are written at the write pointer and read at the read pointer. Pointers wrap modulo DEPTH.
  - count: +1 on enq only, -1 on deq only, unchanged when both or neither occur.
  - enq and deq in the same cycle are legal whenever not full. When full, enq is blocked even if deq occurs.
  - Latency: an entry enqueued into an empty FIFO appears on valid_mem/outputs the next cycle.
  - Head outputs are driven from the read-pointer entry and are stable while valid_mem=1 and no deq occurs.
  - When valid_mem=0, payload outputs are don't-care.
- Branch:
  - When enq occurs with branch_alu=1, the next cycle has branch_taken=1 and branch_target=pc_ex+imm_ex, computed mod 2^DATA_W and latched at enq. Otherwise branch_taken=0 and branch_target holds its last value.
  - The entry itself is still enqueued, so a jal/jalr pc+4 writeback is preserved.
  - Younger instructions are upstream, so buffered entries are never squashed by a branch.
- flush:
  - Next cycle: count=0, pointers=0, valid_mem=0, branch_taken=0.
  - Same-cycle enq and deq are suppressed.
  - flush dominates every other event.
- stall_cycles: increments by 1 every cycle stall_ex=1 and saturates at all-ones. It is not cleared by flush.
- Underflow/overflow is impossible by construction. An assertion flags deq while count==0 or enq while full.

Decomposition:
- Shared package ex_mem_pkg:
  - ctrl bit index constants CTRL_REG_WRITE=0, CTRL_MEM_READ=1, CTRL_MEM_WRITE=2, CTRL_MEM_TO_REG=3.
  - entry width constant ENTRY_W = DATA_W+REG_ADDR_W+4+DATA_W.
- One sub-module, pipe_fifo:
  - generic synchronous FIFO with async active-low reset.
  - ports: push, pop, clear, din, dout, count, full, empty.
  - ex_mem_buffer adds the handshake, branch logic and perf counter around it.

Test Plan:
1. Reset, then valid_ex=1, alu_ready=1, alu_result_ex=0x0000_0010, rd_ex=3, ctrl_ex=0001, data_ready_mem=1 -> next cycle valid_mem=1, alu_result_mem=0x10, rd_mem=3; following cycle count=0.
2. data_ready_mem=0 with three back-to-back valid results 0xA, 0xB, 0xC -> count reaches 2, stall_ex=1 on the third; after data_ready_mem=1, outputs drain in order 0xA, 0xB, 0xC with none lost.
3. valid_ex=1, alu_ready=0 for 5 cycles (fpu busy), then alu_ready=1 with 0x3F80_0000 -> stall_ex=1 for 5 cycles, stall_cycles=5, single entry 0x3F80_0000 enqueued.
4. enq with branch_alu=1, pc_ex=0x100, imm_ex=0xFFFF_FFF0 -> next cycle branch_taken=1, branch_target=0x0F0, lasting one cycle; entry still delivered to mem stage.
5. FIFO holding 2 entries, flush=1 concurrent with a valid enq -> next cycle count=0, valid_mem=0, no branch_taken; a subsequent enq of 0x55 appears normally.
6. rstn driven low mid-cycle while FIFO is full -> outputs clear immediately without a clock edge; operation resumes cleanly after release.

Source files
------------

// File: rtl/ex_mem_buffer_pkg.sv
// Shared constants for the execute/memory decoupling buffer: control-bit
// positions inside ctrl_ex/ctrl_mem and the packed FIFO entry width.
package ex_mem_pkg;

  localparam int CTRL_W          = 4;
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;

  // Entry layout, MSB first: {alu_result, rd, ctrl, store_data}.
  function automatic int entry_width(input int data_w, input int reg_addr_w);
    return data_w + reg_addr_w + CTRL_W + data_w;
  endfunction

  localparam int ENTRY_W = entry_width(DEF_DATA_W, DEF_REG_ADDR_W);

endpackage

// File: rtl/ex_mem_buffer_if.sv
// Execute-side and memory-side bus of ex_mem_buffer. The slave modport is the
// buffer itself; the master modport is whoever drives execute and sinks memory.
interface ex_mem_buffer_if
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) ();

  logic                  valid_ex;
  logic                  alu_ready;
  logic [DATA_W-1:0]     alu_result_ex;
  logic                  branch_alu;
  logic [DATA_W-1:0]     pc_ex;
  logic [DATA_W-1:0]     imm_ex;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic [CTRL_W-1:0]     ctrl_ex;
  logic [DATA_W-1:0]     store_data_ex;
  logic                  flush;
  logic                  data_ready_mem;

  logic                  valid_mem;
  logic [DATA_W-1:0]     alu_result_mem;
  logic [REG_ADDR_W-1:0] rd_mem;
  logic [CTRL_W-1:0]     ctrl_mem;
  logic [DATA_W-1:0]     store_data_mem;
  logic                  stall_ex;
  logic                  branch_taken;
  logic [DATA_W-1:0]     branch_target;

  modport slave (
    input  valid_ex, alu_ready, alu_result_ex, branch_alu, pc_ex, imm_ex,
           rd_ex, ctrl_ex, store_data_ex, flush, data_ready_mem,
    output valid_mem, alu_result_mem, rd_mem, ctrl_mem, store_data_mem,
           stall_ex, branch_taken, branch_target
  );

  modport master (
    output valid_ex, alu_ready, alu_result_ex, branch_alu, pc_ex, imm_ex,
           rd_ex, ctrl_ex, store_data_ex, flush, data_ready_mem,
    input  valid_mem, alu_result_mem, rd_mem, ctrl_mem, store_data_mem,
           stall_ex, branch_taken, branch_target
  );

endinterface

// File: rtl/ex_mem_buffer_pipe_fifo.sv
// Generic in-order FIFO with power-of-two depth. The caller guarantees push
// only when not full and pop only when not empty; clear beats both.
module pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; an entry is only observed after it was written, and dout is masked when empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  a_no_underflow : assert property (@(posedge clk) disable iff (!rstn) !(pop && empty));
  a_no_overflow  : assert property (@(posedge clk) disable iff (!rstn) !(push && full));

endmodule

// File: rtl/ex_mem_buffer.sv
// EX/MEM decoupling buffer: queues completed execute results for the memory
// stage, stalls execute on a busy alu or full queue, and pulses branch redirects.
module ex_mem_buffer
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  ex_mem_buffer_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam int E_W = entry_width(DATA_W, REG_ADDR_W);

  logic           fifo_full;
  logic           fifo_empty;
  logic           enq;
  logic           deq;
  logic [E_W-1:0] entry_in;
  logic [E_W-1:0] entry_out;

  logic              branch_taken_q,  branch_taken_d;
  logic [DATA_W-1:0] branch_target_q, branch_target_d;
  logic [CNT_W-1:0]  stall_cycles_q,  stall_cycles_d;

  // Handshake terms; flush suppresses both queue operations in its cycle.
  assign enq         = bus.valid_ex & bus.alu_ready & ~fifo_full & ~bus.flush;
  assign deq         = bus.valid_mem & bus.data_ready_mem & ~bus.flush;
  assign bus.stall_ex = bus.valid_ex & (~bus.alu_ready | fifo_full);

  assign entry_in = {bus.alu_result_ex, bus.rd_ex, bus.ctrl_ex, bus.store_data_ex};

  pipe_fifo #(
    .WIDTH (E_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (enq),
    .pop   (deq),
    .clear (bus.flush),
    .din   (entry_in),
    .dout  (entry_out),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.valid_mem = ~fifo_empty;
  assign {bus.alu_result_mem, bus.rd_mem, bus.ctrl_mem, bus.store_data_mem} = entry_out;

  // The taken entry is still queued so a link-register writeback survives the redirect.
  always_comb begin
    branch_taken_d  = enq & bus.branch_alu;
    branch_target_d = branch_target_q;
    if (enq && bus.branch_alu) begin
      branch_target_d = bus.pc_ex + bus.imm_ex;
    end
    stall_cycles_d = stall_cycles_q;
    if (bus.stall_ex && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
      stall_cycles_q  <= '0;
    end else begin
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign bus.branch_taken  = branch_taken_q;
  assign bus.branch_target = branch_target_q;
  assign stall_cycles      = stall_cycles_q;

endmodule
